reg_rename_file: RTL and testbench
==================================

// Module: reg_rename_file
// PURPOSE
//  Architectural register file plus rename table. Sits downstream of ROB commit
//  (consumes RF_write_flag/RF_rd/RF_ROB_idx/RF_val) and beside dispatch: supplies
//  operand values or the pending ROB tag for rs1/rs2, and records the new ROB tag
//  for rd of each dispatched instruction. Flushes all rename state on ROB_roll.
// PARAMETERS
//  REG_NUM     32  architectural registers (x0 hardwired to zero)
//  REG_W       5   register index width
//  ROB_W       4   ROB tag width (must match ROB_INDEX_RANGE)
//  XLEN        32  data width
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      asynchronous, active-high reset
//  rdy            in   1      global ready; low = freeze all state
//  Dis_flag       in   1      dispatch of an instruction that writes rd this cycle
//  Dis_rd         in   REG_W  destination of dispatched instruction
//  Dis_ROB_idx    in   ROB_W  ROB tag allocated to it (ROB_nex_idx)
//  Dis_rs1        in   REG_W  source 1 index
//  Dis_rs2        in   REG_W  source 2 index
//  Dis_Q1_flag    out  1      rs1 pending on ROB entry Dis_Q1_idx
//  Dis_Q1_idx     out  ROB_W  producing ROB tag for rs1 (valid when Dis_Q1_flag)
//  Dis_V1         out  XLEN   rs1 value (valid when !Dis_Q1_flag)
//  Dis_Q2_flag    out  1      as Q1 for rs2
//  Dis_Q2_idx     out  ROB_W  as Q1 for rs2
//  Dis_V2         out  XLEN   as V1 for rs2
//  RF_write_flag  in   1      ROB commit writes a register
//  RF_rd          in   REG_W  committed destination
//  RF_ROB_idx     in   ROB_W  ROB tag of committed instruction
//  RF_val         in   XLEN   committed value
//  ROB_roll       in   1      misprediction flush, one-cycle pulse
// BEHAVIOUR
//  State per reg: val[XLEN], busy, tag[ROB_W]. rst: all val=0, busy=0, tag=0;
//   read outputs therefore reset to Q flags=0, idx=0, V=0.
//  Reads combinational (0-cycle), for each rs in {rs1,rs2}:
//   rs==0 -> flag=0, V=0, idx=0.
//   else if commit this cycle (RF_write_flag, RF_rd==rs, busy[rs], tag[rs]==RF_ROB_idx)
//     -> flag=0, V=RF_val (commit bypass; retiring producer not reported pending).
//   else flag=busy[rs], idx=tag[rs], V=val[rs].
//   Reads never see this cycle's Dis_flag rename (dispatch orders rd update after
//   its own reads, so rs==rd of the same instruction returns the old mapping).
//  Sequential update on posedge clk when rdy=1 and rst=0:
//   commit: if RF_write_flag && RF_rd!=0: val[RF_rd]<=RF_val;
//     if busy && tag==RF_ROB_idx -> busy<=0 (else a younger rename owns it; keep).
//   dispatch: if Dis_flag && Dis_rd!=0 && !ROB_roll: busy<=1, tag<=Dis_ROB_idx.
//   same rd in commit and dispatch same cycle: val written, busy=1, tag=Dis_ROB_idx
//     (dispatch wins for busy/tag).
//   ROB_roll=1: every busy<=0 after applying the commit value write of the same
//     cycle (ROB asserts roll with the JALR commit write); dispatch ignored; tags kept.
//  rdy=0: no state change; reads still combinational.
//  x0: never written, never busy, whatever the inputs.
//  Tag wrap-around: tags compared for equality only; ROB guarantees no live alias.
//  rst asserted mid-operation: immediate clear, pending commits/dispatches lost.
// STRUCTURE
//  Shared package/define.v: REG_INDEX_RANGE, ROB_INDEX_RANGE, REG_NUM, TRUE/FALSE.
//  One sub-module natural: rrf_read_port (combinational lookup + commit bypass),
//   instantiated twice for rs1/rs2. State arrays and update logic stay top-level.
// TESTING
//  1 reset: rst pulse, read rs1=5,rs2=0 -> Q flags 0, V1=V2=0.
//  2 rename+commit: dispatch rd=3 tag=7; next cycle rs1=3 -> Q1=1 idx=7; commit
//    rd=3 tag=7 val=0xDEAD -> same-cycle V1=0xDEAD Q1=0; after edge busy[3]=0.
//  3 stale commit: rename x4 tag=2, then x4 tag=9; commit x4 tag=2 val=0x11 ->
//    val[4]=0x11 but Q=1 idx=9 persists; commit tag=9 val=0x22 -> Q=0 V=0x22.
//  4 same-cycle: busy x6 tag=1; commit x6 tag=1 val=5 plus dispatch rd=6 tag=3 ->
//    next cycle Q=1 idx=3, val[6]=5.
//  5 rollback: rename x1,x2,x3; ROB_roll + commit x1 val=0x40 + Dis_flag rd=2 ->
//    all Q=0, V(x1)=0x40, x2/x3 old values.
//  6 x0 and rdy: dispatch/commit rd=0 val=0xFF -> x0 reads 0; rdy=0 with commit
//    x5 val=9 -> val[5] unchanged after edge.

Source files
------------

// File: rtl/reg_rename_file_pkg.sv
// Shared widths and types for the architectural register file and rename table.
package reg_rename_file_pkg;
    localparam int REG_NUM = 32;
    localparam int REG_W   = 5;
    localparam int ROB_W   = 4;
    localparam int XLEN    = 32;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [ROB_W-1:0] rob_idx_t;
    typedef logic [XLEN-1:0]  word_t;
endpackage

// File: rtl/reg_rename_file_if.sv
// Dispatch lookup/rename and ROB commit/flush signals of the rename register file.
// Valid/ready: there is no per-transfer handshake; Dis_flag and RF_write_flag are
// qualifiers sampled on a rising edge only while the global rdy is high.
interface reg_rename_file_if;
    import reg_rename_file_pkg::*;

    logic     Dis_flag;
    reg_idx_t Dis_rd;
    rob_idx_t Dis_ROB_idx;
    reg_idx_t Dis_rs1;
    reg_idx_t Dis_rs2;
    logic     Dis_Q1_flag;
    rob_idx_t Dis_Q1_idx;
    word_t    Dis_V1;
    logic     Dis_Q2_flag;
    rob_idx_t Dis_Q2_idx;
    word_t    Dis_V2;
    logic     RF_write_flag;
    reg_idx_t RF_rd;
    rob_idx_t RF_ROB_idx;
    word_t    RF_val;
    logic     ROB_roll;

    modport master (
        output Dis_flag, Dis_rd, Dis_ROB_idx, Dis_rs1, Dis_rs2,
        output RF_write_flag, RF_rd, RF_ROB_idx, RF_val, ROB_roll,
        input  Dis_Q1_flag, Dis_Q1_idx, Dis_V1, Dis_Q2_flag, Dis_Q2_idx, Dis_V2
    );

    modport slave (
        input  Dis_flag, Dis_rd, Dis_ROB_idx, Dis_rs1, Dis_rs2,
        input  RF_write_flag, RF_rd, RF_ROB_idx, RF_val, ROB_roll,
        output Dis_Q1_flag, Dis_Q1_idx, Dis_V1, Dis_Q2_flag, Dis_Q2_idx, Dis_V2
    );
endinterface

// File: rtl/reg_rename_file_rrf_read_port.sv
// One combinational operand lookup: value or pending ROB tag, with commit bypass.
module rrf_read_port
    import reg_rename_file_pkg::*;
(
    input  reg_idx_t           rs,
    input  logic [REG_NUM-1:0] busy,
    input  rob_idx_t           tag [REG_NUM],
    input  word_t              val [REG_NUM],
    input  logic               commit_flag,
    input  reg_idx_t           commit_rd,
    input  rob_idx_t           commit_idx,
    input  word_t              commit_val,
    output logic               q_flag,
    output rob_idx_t           q_idx,
    output word_t              v
);
    always_comb begin
        q_flag = 1'b0;
        q_idx  = '0;
        v      = '0;
        if (rs != '0) begin
            q_idx = tag[rs];
            // The retiring producer's value is forwarded so it is never reported pending.
            if (commit_flag && commit_rd == rs && busy[rs] && tag[rs] == commit_idx) begin
                v = commit_val;
            end else begin
                q_flag = busy[rs];
                v      = val[rs];
            end
        end
    end
endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file plus rename table: commit writes, dispatch renames, roll flushes.
module reg_rename_file
    import reg_rename_file_pkg::*;
(
    input logic              clk,
    input logic              rst,
    input logic              rdy,
    reg_rename_file_if.slave bus
);
    word_t              val  [REG_NUM];
    rob_idx_t           tag  [REG_NUM];
    logic [REG_NUM-1:0] busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val[i] <= '0;
                tag[i] <= '0;
            end
            busy <= '0;
        end else if (rdy) begin
            if (bus.RF_write_flag && bus.RF_rd != '0) begin
                val[bus.RF_rd] <= bus.RF_val;
                // A stale tag means a younger rename owns the register; leave it busy.
                if (busy[bus.RF_rd] && tag[bus.RF_rd] == bus.RF_ROB_idx) begin
                    busy[bus.RF_rd] <= 1'b0;
                end
            end
            // Placed after the commit so a same-register dispatch wins busy/tag.
            if (bus.Dis_flag && bus.Dis_rd != '0 && !bus.ROB_roll) begin
                busy[bus.Dis_rd] <= 1'b1;
                tag[bus.Dis_rd]  <= bus.Dis_ROB_idx;
            end
            if (bus.ROB_roll) begin
                busy <= '0;
            end
        end
    end

    rrf_read_port u_read_rs1 (
        .rs          (bus.Dis_rs1),
        .busy        (busy),
        .tag         (tag),
        .val         (val),
        .commit_flag (bus.RF_write_flag),
        .commit_rd   (bus.RF_rd),
        .commit_idx  (bus.RF_ROB_idx),
        .commit_val  (bus.RF_val),
        .q_flag      (bus.Dis_Q1_flag),
        .q_idx       (bus.Dis_Q1_idx),
        .v           (bus.Dis_V1)
    );

    rrf_read_port u_read_rs2 (
        .rs          (bus.Dis_rs2),
        .busy        (busy),
        .tag         (tag),
        .val         (val),
        .commit_flag (bus.RF_write_flag),
        .commit_rd   (bus.RF_rd),
        .commit_idx  (bus.RF_ROB_idx),
        .commit_val  (bus.RF_val),
        .q_flag      (bus.Dis_Q2_flag),
        .q_idx       (bus.Dis_Q2_idx),
        .v           (bus.Dis_V2)
    );
endmodule

// File: tb/tb_reg_rename_file.sv
// Directed vector bench for reg_rename_file: one vector per clock, reads checked before the edge.
module tb_reg_rename_file;
    import reg_rename_file_pkg::*;

    typedef struct {
        logic     dis_flag;
        reg_idx_t dis_rd;
        rob_idx_t dis_rob;
        reg_idx_t rs1;
        reg_idx_t rs2;
        logic     wflag;
        reg_idx_t rf_rd;
        rob_idx_t rf_rob;
        word_t    rf_val;
        logic     roll;
        logic     rdy;
        logic     e1f;
        rob_idx_t e1i;
        word_t    e1v;
        logic     e2f;
        rob_idx_t e2i;
        word_t    e2v;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    reg_rename_file_if bus ();

    reg_rename_file dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    // clock/reset
    always #5 clk = ~clk;

    function automatic vec_t mk(
        logic df, reg_idx_t drd, rob_idx_t drob, reg_idx_t r1, reg_idx_t r2,
        logic wf, reg_idx_t crd, rob_idx_t crob, word_t cval, logic rl, logic ry,
        logic f1, rob_idx_t i1, word_t v1, logic f2, rob_idx_t i2, word_t v2);
        vec_t t;
        t.dis_flag = df;  t.dis_rd = drd; t.dis_rob = drob;
        t.rs1 = r1;       t.rs2 = r2;
        t.wflag = wf;     t.rf_rd = crd;  t.rf_rob = crob; t.rf_val = cval;
        t.roll = rl;      t.rdy = ry;
        t.e1f = f1;       t.e1i = i1;     t.e1v = v1;
        t.e2f = f2;       t.e2i = i2;     t.e2v = v2;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.Dis_flag      = t.dis_flag;
        bus.Dis_rd        = t.dis_rd;
        bus.Dis_ROB_idx   = t.dis_rob;
        bus.Dis_rs1       = t.rs1;
        bus.Dis_rs2       = t.rs2;
        bus.RF_write_flag = t.wflag;
        bus.RF_rd         = t.rf_rd;
        bus.RF_ROB_idx    = t.rf_rob;
        bus.RF_val        = t.rf_val;
        bus.ROB_roll      = t.roll;
        rdy               = t.rdy;
    endtask

    // Tag is only meaningful when pending, except x0 which must read all-zero.
    task automatic check_port(input string pfx, input reg_idx_t rs,
                              input logic af, input rob_idx_t ai, input word_t av,
                              input logic ef, input rob_idx_t ei, input word_t ev);
        check({pfx, " flag"}, {31'd0, af}, {31'd0, ef});
        if (ef || rs == '0) check({pfx, " idx"}, {28'd0, ai}, {28'd0, ei});
        check({pfx, " val"}, av, ev);
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,0, 0,0, 0,0,0,0, 0,1, 0,0,0, 0,0,0);

        //           dis        rs1 rs2  commit               roll rdy  exp rs1          exp rs2
        // reset state
        vecs.push_back(mk(0,0,0,  5,0,  0,0,0,32'h0,          0,1,  0,0,32'h0,    0,0,32'h0));
        // rename + commit bypass
        vecs.push_back(mk(1,3,7,  3,0,  0,0,0,32'h0,          0,1,  0,0,32'h0,    0,0,32'h0));
        vecs.push_back(mk(0,0,0,  3,0,  0,0,0,32'h0,          0,1,  1,7,32'h0,    0,0,32'h0));
        vecs.push_back(mk(0,0,0,  3,3,  1,3,7,32'hdead,       0,1,  0,0,32'hdead, 0,0,32'hdead));
        vecs.push_back(mk(0,0,0,  3,3,  0,0,0,32'h0,          0,1,  0,0,32'hdead, 0,0,32'hdead));
        // stale commit keeps the younger rename
        vecs.push_back(mk(1,4,2,  4,0,  0,0,0,32'h0,          0,1,  0,0,32'h0,    0,0,32'h0));
        vecs.push_back(mk(1,4,9,  4,0,  0,0,0,32'h0,          0,1,  1,2,32'h0,    0,0,32'h0));
        vecs.push_back(mk(0,0,0,  4,0,  1,4,2,32'h11,         0,1,  1,9,32'h0,    0,0,32'h0));
        vecs.push_back(mk(0,0,0,  4,0,  0,0,0,32'h0,          0,1,  1,9,32'h11,   0,0,32'h0));
        vecs.push_back(mk(0,0,0,  4,0,  1,4,9,32'h22,         0,1,  0,0,32'h22,   0,0,32'h0));
        vecs.push_back(mk(0,0,0,  4,0,  0,0,0,32'h0,          0,1,  0,0,32'h22,   0,0,32'h0));
        // same-cycle commit and dispatch to one register
        vecs.push_back(mk(1,6,1,  6,0,  0,0,0,32'h0,          0,1,  0,0,32'h0,    0,0,32'h0));
        vecs.push_back(mk(1,6,3,  6,0,  1,6,1,32'h5,          0,1,  0,0,32'h5,    0,0,32'h0));
        vecs.push_back(mk(0,0,0,  6,0,  0,0,0,32'h0,          0,1,  1,3,32'h5,    0,0,32'h0));
        // rollback with commit write, dispatch ignored
        vecs.push_back(mk(1,1,4,  1,2,  0,0,0,32'h0,          0,1,  0,0,32'h0,    0,0,32'h0));
        vecs.push_back(mk(1,2,5,  1,2,  0,0,0,32'h0,          0,1,  1,4,32'h0,    0,0,32'h0));
        vecs.push_back(mk(1,3,6,  2,3,  0,0,0,32'h0,          0,1,  1,5,32'h0,    0,0,32'hdead));
        vecs.push_back(mk(1,2,8,  1,3,  1,1,4,32'h40,         1,1,  0,0,32'h40,   1,6,32'hdead));
        vecs.push_back(mk(0,0,0,  1,2,  0,0,0,32'h0,          0,1,  0,0,32'h40,   0,0,32'h0));
        vecs.push_back(mk(0,0,0,  3,6,  0,0,0,32'h0,          0,1,  0,0,32'hdead, 0,0,32'h5));
        // x0 is immutable
        vecs.push_back(mk(1,0,3,  0,0,  1,0,3,32'hff,         0,1,  0,0,32'h0,    0,0,32'h0));
        vecs.push_back(mk(0,0,0,  0,0,  0,0,0,32'h0,          0,1,  0,0,32'h0,    0,0,32'h0));
        // rdy low freezes state
        vecs.push_back(mk(1,7,2,  5,7,  1,5,0,32'h9,          0,0,  0,0,32'h0,    0,0,32'h0));
        vecs.push_back(mk(0,0,0,  5,7,  0,0,0,32'h0,          0,1,  0,0,32'h0,    0,0,32'h0));
        // commit to a non-busy register: no bypass, value lands after the edge
        vecs.push_back(mk(0,0,0,  5,0,  1,5,0,32'h9,          0,1,  0,0,32'h0,    0,0,32'h0));
        vecs.push_back(mk(0,0,0,  5,0,  0,0,0,32'h0,          0,1,  0,0,32'h9,    0,0,32'h0));

        drive(idle);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #2;
            check_port($sformatf("v%0d rs1", i), vecs[i].rs1,
                       bus.Dis_Q1_flag, bus.Dis_Q1_idx, bus.Dis_V1,
                       vecs[i].e1f, vecs[i].e1i, vecs[i].e1v);
            check_port($sformatf("v%0d rs2", i), vecs[i].rs2,
                       bus.Dis_Q2_flag, bus.Dis_Q2_idx, bus.Dis_V2,
                       vecs[i].e2f, vecs[i].e2i, vecs[i].e2v);
            @(negedge clk);
        end

        // Rename x9, then assert rst between edges: state must clear without a clock edge.
        drive(mk(1,9,1, 9,5, 0,0,0,32'h0, 0,1, 0,0,0, 0,0,0));
        @(negedge clk);
        drive(mk(0,0,0, 9,5, 0,0,0,32'h0, 0,1, 0,0,0, 0,0,0));
        #1;
        check_port("pre_rst x9", 5'd9, bus.Dis_Q1_flag, bus.Dis_Q1_idx, bus.Dis_V1,
                   1'b1, 4'd1, 32'h0);
        check_port("pre_rst x5", 5'd5, bus.Dis_Q2_flag, bus.Dis_Q2_idx, bus.Dis_V2,
                   1'b0, 4'd0, 32'h9);
        rst = 1'b1;
        #1;
        check_port("async_rst x9", 5'd9, bus.Dis_Q1_flag, bus.Dis_Q1_idx, bus.Dis_V1,
                   1'b0, 4'd0, 32'h0);
        check_port("async_rst x5", 5'd5, bus.Dis_Q2_flag, bus.Dis_Q2_idx, bus.Dis_V2,
                   1'b0, 4'd0, 32'h0);
        // Dispatch and commit held during reset must be lost.
        drive(mk(1,9,2, 9,5, 1,5,0,32'h77, 0,1, 0,0,0, 0,0,0));
        @(negedge clk);
        drive(mk(0,0,0, 9,5, 0,0,0,32'h0, 0,1, 0,0,0, 0,0,0));
        rst = 1'b0;
        #2;
        check_port("post_rst x9", 5'd9, bus.Dis_Q1_flag, bus.Dis_Q1_idx, bus.Dis_V1,
                   1'b0, 4'd0, 32'h0);
        check_port("post_rst x5", 5'd5, bus.Dis_Q2_flag, bus.Dis_Q2_idx, bus.Dis_V2,
                   1'b0, 4'd0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
